imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the byte-wide instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes the bytes sequentially into instruction memory. Instructions are stored low byte at the lower address.
- Holds the CPU in reset while loading, verifies an 8-bit checksum, and reports done or error.
- Sits between the board's input source (switches, UART receiver, or testbench) and the instruction-memory write port.

Parameters:
- TIMEOUT_CYCLES, 0: maximum idle cycles between accepted bytes while loading. 0 disables the timeout.
- REQUIRE_EVEN, 1: when 1, an odd payload length is rejected, because instructions are 16 bits wide.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction-memory write strobe, one cycle per byte
- mem_waddr  out  8  write address
- mem_wdata  out  8  write data
- cpu_hold  out  1  holds the CPU in reset while loading
- busy  out  1  FSM is in HDR_ADDR, HDR_LEN, DATA or CSUM
- done  out  1  sticky: load completed and checksum valid
- error  out  1  sticky: checksum, length or timeout failure
- err_code  out  2  0 none, 1 checksum, 2 odd length, 3 timeout

Behaviour:
- Frame format: byte0 = start address A; byte1 = length L (0 means 256); L payload bytes; 1 checksum byte.
  - Frame is valid when the sum of all L+3 bytes mod 256 == 0.
- Transfer rule: a byte transfers on a rising edge where in_valid && in_ready.
  - in_ready is combinational from state only: 1 in HDR_ADDR, HDR_LEN, DATA, CSUM; 0 elsewhere.
  - in_ready does not depend on in_valid.
- States:
  - IDLE: start -> HDR_ADDR, clear done/error/err_code, set cpu_hold.
  - HDR_ADDR: on transfer, latch ptr = A, sum = A -> HDR_LEN.
  - HDR_LEN: on transfer, sum += L; cnt = (L==0 ? 256 : L), counter is 9 bits.
    - If REQUIRE_EVEN and L[0]==1 -> ERROR, err_code = 2.
    - Otherwise -> DATA.
  - DATA: on transfer, register mem_we=1, mem_waddr=ptr, mem_wdata=byte for exactly the next cycle; ptr += 1 (wraps 255->0); sum += byte; cnt -= 1. When cnt reaches 0 -> CSUM.
  - CSUM: on transfer, if (sum + byte) mod 256 == 0 -> DONE, otherwise -> ERROR with err_code = 1.
  - DONE: done=1, cpu_hold=0. start -> HDR_ADDR (new load).
  - ERROR: error=1, cpu_hold stays 1 so the CPU is not run from a corrupt image. start -> HDR_ADDR.
- Write latency: mem_we rises one cycle after the accepted DATA byte.
  - Memory samples on the falling edge inside that cycle.
  - Back-to-back transfers give back-to-back strobes with consecutive addresses.
  - mem_we is never high in any state other than one cycle after a DATA transfer.
- Bytes already written are not rolled back on checksum error.
- Timeout (TIMEOUT_CYCLES > 0):
  - Idle counter clears on every transfer and on entry to HDR_ADDR.
  - Counter increments each busy cycle without a transfer.
  - Reaching TIMEOUT_CYCLES -> ERROR, err_code = 3.
- start while busy is ignored. in_valid outside busy states is ignored; no transfer occurs.
- Address wrap: A=0xFE, L=4 writes 0xFE, 0xFF, 0x00, 0x01.
- Reset (any state, including mid-frame):
  - State -> IDLE.
  - in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, err_code=0.
  - No write strobe is issued in the cycle after reset, even if a DATA transfer coincided with the reset edge.
- cpu_hold rules:
  - Stays 1 out of reset until the first successful load.
  - Is 1 whenever busy.

Test Plan:
- Frame 04 02 70 00 8A with continuous valid, after start:
  - mem_we pulses at addresses 0x04 then 0x05, data 0x70 then 0x00, on consecutive cycles.
  - done=1, cpu_hold=0, error=0.
- Same frame with checksum 8B:
  - Both writes still occur.
  - error=1, err_code=1, done=0, cpu_hold=1.
- Frame FE 04 11 22 33 44 + correct checksum, with in_valid dropped for 3 cycles between every byte:
  - Writes land at 0xFE, 0xFF, 0x00, 0x01.
  - No extra strobes during gaps; done=1.
- Header 10 03:
  - ERROR, err_code=2, no mem_we.
  - Subsequent start plus a valid frame -> done.
- TIMEOUT_CYCLES=8, stream stops after 1 payload byte:
  - error=1, err_code=3 exactly 8 cycles after the last transfer.
- rst asserted on the same edge as the 2nd DATA transfer:
  - Next cycle all outputs are at reset values and mem_we=0.
  - start plus a full frame afterwards completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes the byte-wide instruction memory
// Frame: address, length (0 = 256), payload, checksum; the CPU is held in reset until a clean load completes.
module imem_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter bit          REQUIRE_EVEN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ADDR,
    S_HDR_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_ODD     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  sum_q, sum_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] idle_q, idle_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_waddr_q, mem_waddr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic        xfer;
  logic [7:0]  sum_next;

  assign xfer     = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  // Reset also squashes a strobe that a DATA transfer on the reset edge would have produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 8'd0;
      sum_q       <= 8'd0;
      cnt_q       <= 9'd0;
      idle_q      <= 32'd0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= 8'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR_ADDR;
          err_code_d = ERR_NONE;
          idle_d     = 32'd0;
        end
      end
      S_HDR_ADDR: begin
        if (xfer) begin
          ptr_d   = in_data;
          sum_d   = in_data;
          state_d = S_HDR_LEN;
        end
      end
      S_HDR_LEN: begin
        if (xfer) begin
          sum_d = sum_next;
          cnt_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          if (REQUIRE_EVEN && in_data[0]) begin
            state_d    = S_ERROR;
            err_code_d = ERR_ODD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = ptr_q;
          mem_wdata_d = in_data;
          ptr_d       = ptr_q + 8'd1;
          sum_d       = sum_next;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (sum_next == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A transfer always resets the idle count; only stalls inside a frame advance it.
    if (busy) begin
      if (xfer) begin
        idle_d = 32'd0;
      end else if (TIMEOUT_CYCLES != 0) begin
        idle_d = idle_q + 32'd1;
        if (idle_q + 32'd1 == TIMEOUT_CYCLES) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_HDR_ADDR, S_HDR_LEN, S_DATA, S_CSUM: busy = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
    in_ready = busy;
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-level reference model
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] got_w[$];
  int          got_c[$];
  logic [15:0] exp_w[$];
  logic        exp_done;
  logic [1:0]  exp_code;

  imem_loader #(.TIMEOUT_CYCLES(8), .REQUIRE_EVEN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      got_w.push_back({mem_waddr, mem_wdata});
      got_c.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Holds the byte until the loader takes it; a stuck loader is reported, not waited on forever.
  task automatic put_byte(input logic [7:0] b, input bit noise_start);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    start    = noise_start;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        tick(1);
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!ok) check_eq("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference: what a frame must write and how it must end, from the frame rules alone.
  task automatic model_frame(input logic [7:0] fr[$]);
    int len;
    logic [7:0] s;
    logic [7:0] l;
    exp_w.delete();
    l = fr[1];
    if (l[0]) begin
      exp_done = 1'b0;
      exp_code = 2'd2;
      return;
    end
    len = (l == 8'd0) ? 256 : int'(l);
    s = 8'd0;
    foreach (fr[i]) s = s + fr[i];
    for (int i = 0; i < len; i++) exp_w.push_back({8'(fr[0] + i), fr[2 + i]});
    exp_done = (s == 8'd0);
    exp_code = exp_done ? 2'd0 : 2'd1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
  endtask

  task automatic check_end(input string tag);
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_error"}, error, !exp_done);
    check_eq({tag, "_code"}, err_code, exp_code);
    check_eq({tag, "_hold"}, cpu_hold, !exp_done);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] fr[$], input int gmin, input int gmax,
                           input bit noise);
    got_w.delete();
    got_c.delete();
    model_frame(fr);
    pulse_start();
    foreach (fr[i]) begin
      if (i > 0) tick($urandom_range(gmax, gmin));
      put_byte(fr[i], noise && ($urandom_range(0, 3) == 0));
    end
    tick(3);
    compare_writes(tag);
    check_end(tag);
  endtask

  function automatic logic [7:0] fsum(input logic [7:0] fr[$]);
    logic [7:0] s;
    s = 8'd0;
    foreach (fr[i]) s = s + fr[i];
    return s;
  endfunction

  initial begin
    logic [7:0] fr[$];
    logic [7:0] a;
    logic [7:0] l;
    int len;
    int n;
    int r;

    tick(3);
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_waddr", mem_waddr, 8'd0);
    check_eq("rst_wdata", mem_wdata, 8'd0);
    check_eq("rst_hold", cpu_hold, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_code", err_code, 2'd0);

    in_valid = 1'b1;
    in_data  = 8'h55;
    tick(2);
    in_valid = 1'b0;
    check_eq("idle_ignore_valid", got_w.size(), 0);

    fr = '{8'h04, 8'h02, 8'h70, 8'h00, 8'h8A};
    run_frame("basic", fr, 0, 0, 1'b0);
    if (got_c.size() == 2) check_eq("basic_b2b", got_c[1] - got_c[0], 1);

    fr = '{8'h04, 8'h02, 8'h70, 8'h00, 8'h8B};
    run_frame("badsum", fr, 0, 0, 1'b0);

    fr = '{8'hFE, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    fr.push_back(8'(-fsum(fr)));
    run_frame("wrap_gap", fr, 3, 3, 1'b0);

    fr = '{8'h10, 8'h03};
    run_frame("odd", fr, 0, 0, 1'b0);
    fr = '{8'h30, 8'h02, 8'hAB, 8'hCD};
    fr.push_back(8'(-fsum(fr)));
    run_frame("after_odd", fr, 0, 1, 1'b0);

    got_w.delete();
    pulse_start();
    put_byte(8'h40, 1'b0);
    put_byte(8'h04, 1'b0);
    put_byte(8'h99, 1'b0);
    n = 0;
    while (!error && n < 30) begin
      tick(1);
      n++;
    end
    check_eq("tmo_latency", n, 8);
    check_eq("tmo_code", err_code, 2'd3);
    check_eq("tmo_hold", cpu_hold, 1'b1);
    check_eq("tmo_writes", got_w.size(), 1);

    got_w.delete();
    pulse_start();
    put_byte(8'h20, 1'b0);
    put_byte(8'h04, 1'b0);
    put_byte(8'h01, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h02;
    rst      = 1'b1;
    tick(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("mrst_mem_we", mem_we, 1'b0);
    check_eq("mrst_in_ready", in_ready, 1'b0);
    check_eq("mrst_waddr", mem_waddr, 8'd0);
    check_eq("mrst_wdata", mem_wdata, 8'd0);
    check_eq("mrst_hold", cpu_hold, 1'b1);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_flags", {done, error, err_code}, 4'd0);
    tick(2);
    check_eq("mrst_nwrites", got_w.size(), 1);
    fr = '{8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    fr.push_back(8'(-fsum(fr)));
    run_frame("after_rst", fr, 0, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      a = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      l = 8'd0;
      else if (r == 1) l = 8'(2 * $urandom_range(0, 10) + 1);
      else             l = 8'(2 * $urandom_range(1, 10));
      fr = '{a, l};
      if (!l[0]) begin
        len = (l == 8'd0) ? 256 : int'(l);
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        if ($urandom_range(0, 3) == 0) fr.push_back(8'(-fsum(fr) + 8'($urandom_range(1, 255))));
        else                          fr.push_back(8'(-fsum(fr)));
      end
      run_frame($sformatf("rnd%0d", t), fr, 0, 3, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
